// File: rtl/booth_r4_seq_mul_pkg.sv
// Shared types for the radix-4 Booth sequential multiplier: FSM states,
// Booth digit encoding and the triplet-to-digit recoding function.
// Latency: n/a (types and a combinational helper only). Backpressure: n/a.
package booth_r4_seq_mul_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    typedef enum logic [2:0] {
        ZERO = 3'd0,
        POS1 = 3'd1,
        POS2 = 3'd2,
        NEG1 = 3'd3,
        NEG2 = 3'd4
    } booth_digit_e;

    // Radix-4 Booth recoding of {m[i+1], m[i], m[i-1]}.
    function automatic booth_digit_e booth_r4_digit(input logic [2:0] triplet);
        booth_digit_e d;
        case (triplet)
            3'b001, 3'b010: d = POS1;
            3'b011:         d = POS2;
            3'b100:         d = NEG2;
            3'b101, 3'b110: d = NEG1;
            default:        d = ZERO;  // 000 and 111
        endcase
        return d;
    endfunction

endpackage

// File: rtl/booth_r4_seq_mul_if.sv
// Handshake bundle between the issuing stage and the multiplier.
// Latency: n/a (wires only). Backpressure: in_valid/in_ready and out_valid/out_ready pairs.
// master = requester/consumer side, slave = multiplier side.
interface booth_r4_seq_mul_if #(
    parameter int WIDTH = 8
);
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     op_1;
    logic [WIDTH-1:0]     op_2;
    logic                 is_signed;
    logic                 out_valid;
    logic                 out_ready;
    logic [2*WIDTH-1:0]   result;
    logic                 busy;

    modport master (
        output in_valid, op_1, op_2, is_signed, out_ready,
        input  in_ready, out_valid, result, busy
    );

    modport slave (
        input  in_valid, op_1, op_2, is_signed, out_ready,
        output in_ready, out_valid, result, busy
    );

endinterface

// File: rtl/booth_r4_seq_mul_pp.sv
// Booth partial product: digit * mcand, sign-extended to 2*EW bits.
// Latency: combinational. Backpressure: none.
// Ports: digit (Booth digit), mcand (EW-bit signed multiplicand), pp (2*EW-bit product).
module booth_r4_seq_mul_pp
    import booth_r4_seq_mul_pkg::*;
#(
    parameter int EW = 10
) (
    input  booth_digit_e      digit,
    input  logic [EW-1:0]     mcand,
    output logic [2*EW-1:0]   pp
);

    logic [2*EW-1:0] m_ext;
    logic [2*EW-1:0] m_x2;

    always_comb begin
        m_ext = {{EW{mcand[EW-1]}}, mcand};
        m_x2  = m_ext << 1;
        pp    = '0;
        // Negation done at full width, so no separate +1 correction row is needed.
        unique case (digit)
            POS1:    pp = m_ext;
            POS2:    pp = m_x2;
            NEG1:    pp = ~m_ext + 1'b1;
            NEG2:    pp = ~m_x2 + 1'b1;
            default: pp = '0;
        endcase
    end

endmodule

// File: rtl/booth_r4_seq_mul.sv
// Iterative radix-4 Booth multiplier, signed/unsigned per operation, two multiplier bits per clock.
// Latency: out_valid rises WIDTH/2+1 clocks after the accept edge; one operation in flight.
// Backpressure: in_ready only in IDLE; result held in DONE until out_ready.
// Ports: clk, rst (sync active-high), bus (slave: in_valid/in_ready/op_1/op_2/is_signed,
//        out_valid/out_ready/result, busy).
module booth_r4_seq_mul
    import booth_r4_seq_mul_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    booth_r4_seq_mul_if.slave bus
);

    // Two extra bits let unsigned operands be treated as positive signed values.
    localparam int EW     = WIDTH + 2;
    localparam int ACC_W  = 2 * EW;
    localparam int ITER   = EW / 2;
    localparam int STEP_W = $clog2(ITER + 1);
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(ITER - 1);

    state_e               state_q,  state_d;
    logic [EW-1:0]        mcand_q,  mcand_d;
    logic [EW:0]          mult_q,   mult_d;     // extended multiplier plus appended 0 LSB
    logic [ACC_W-1:0]     acc_q,    acc_d;
    logic [STEP_W-1:0]    step_q,   step_d;
    logic [2*WIDTH-1:0]   result_q, result_d;

    booth_digit_e         digit;
    logic [ACC_W-1:0]     pp;
    logic [ACC_W-1:0]     pp_shift;
    logic                 sx_1;
    logic                 sx_2;

    assign digit = booth_r4_digit(mult_q[2:0]);

    booth_r4_seq_mul_pp #(.EW(EW)) u_pp (
        .digit (digit),
        .mcand (mcand_q),
        .pp    (pp)
    );

    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mult_d   = mult_q;
        acc_d    = acc_q;
        step_d   = step_q;
        result_d = result_q;
        sx_1     = bus.is_signed & bus.op_1[WIDTH-1];
        sx_2     = bus.is_signed & bus.op_2[WIDTH-1];
        pp_shift = pp << {step_q, 1'b0};

        unique case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    mcand_d = {{2{sx_1}}, bus.op_1};
                    mult_d  = {{2{sx_2}}, bus.op_2, 1'b0};
                    acc_d   = '0;
                    step_d  = '0;
                    state_d = CALC;
                end
            end
            CALC: begin
                acc_d  = acc_q + pp_shift;
                mult_d = {{2{mult_q[EW]}}, mult_q[EW:2]};
                step_d = step_q + STEP_W'(1);
                if (step_q == LAST_STEP) begin
                    result_d = acc_d[2*WIDTH-1:0];
                    state_d  = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            mcand_q  <= '0;
            mult_q   <= '0;
            acc_q    <= '0;
            step_q   <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mult_q   <= mult_d;
            acc_q    <= acc_d;
            step_q   <= step_d;
            result_q <= result_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.result    = result_q;

endmodule

// File: tb/tb_booth_r4_seq_mul.sv
// Bench for booth_r4_seq_mul (WIDTH=8): vector table, hand-written corner sequences,
// random operations, scoreboard queue filled on drive and drained on output handshake.
module tb_booth_r4_seq_mul;

    localparam int WIDTH = 8;
    localparam int PW    = 2 * WIDTH;
    localparam int ITER  = WIDTH / 2 + 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    booth_r4_seq_mul_if #(.WIDTH(WIDTH)) bus ();

    booth_r4_seq_mul #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             s;
        logic [PW-1:0]    exp;
    } vec_t;

    vec_t          vecs[10];
    logic [PW-1:0] exp_q[$];
    int            errors = 0;
    int            checks = 0;
    int            cyc = 0;
    int            n_acc = 0;
    int            last_acc_cyc = 0;
    int            acc_gap = 0;
    logic          prev_ov = 1'b0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    function automatic logic [PW-1:0] model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                            input logic s);
        longint sa, sb, p;
        sa = s ? longint'($signed(a)) : longint'(a);
        sb = s ? longint'($signed(b)) : longint'(b);
        p  = sa * sb;
        return p[PW-1:0];
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: samples 1ns after the falling edge; a handshake seen here completes on the next rising edge.
    always @(negedge clk) begin
        #1;
        if (!rst) begin
            if (bus.in_valid && bus.in_ready) begin
                acc_gap      = cyc - last_acc_cyc;
                last_acc_cyc = cyc;
                n_acc++;
            end
            if (bus.out_valid && !prev_ov)
                check("latency", 64'(cyc - last_acc_cyc - 1), 64'(ITER));
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_result: got 0x%0h, expected no output", bus.result);
                end else begin
                    check("result", 64'(bus.result), 64'(exp_q.pop_front()));
                end
            end
            prev_ov = bus.out_valid;
        end else begin
            prev_ov = 1'b0;
        end
    end

    task automatic issue(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic s,
                         input logic [PW-1:0] exp, input logic hold);
        int target;
        int n;
        @(negedge clk);
        bus.op_1      = a;
        bus.op_2      = b;
        bus.is_signed = s;
        bus.in_valid  = 1'b1;
        exp_q.push_back(exp);
        target = n_acc + 1;
        n = 0;
        #2;
        while (n_acc < target && n < 100) begin
            @(negedge clk);
            #2;
            n++;
        end
        if (n_acc < target) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got no accept in %0d cycles, expected accept", n);
        end
        if (!hold) begin
            @(negedge clk);
            bus.in_valid = 1'b0;
        end
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d pending results, expected 0", exp_q.size());
        end
    endtask

    initial begin
        int n;
        logic [WIDTH-1:0] ra, rb;
        logic             rs;

        vecs[0] = '{8'h80, 8'h80, 1'b1, 16'h4000};  // -128 * -128
        vecs[1] = '{8'hFF, 8'hFF, 1'b0, 16'hFE01};  // 255 * 255
        vecs[2] = '{8'hFF, 8'h01, 1'b1, 16'hFFFF};  // -1 * 1
        vecs[3] = '{8'h7F, 8'h80, 1'b1, 16'hC080};  // 127 * -128
        vecs[4] = '{8'h03, 8'h05, 1'b0, 16'h000F};
        vecs[5] = '{8'h00, 8'hA5, 1'b1, 16'h0000};
        vecs[6] = '{8'h80, 8'h7F, 1'b0, 16'h3F80};  // 128 * 127
        vecs[7] = '{8'hFF, 8'hFF, 1'b1, 16'h0001};  // -1 * -1
        vecs[8] = '{8'h80, 8'h02, 1'b0, 16'h0100};
        vecs[9] = '{8'h81, 8'h03, 1'b1, 16'hFE83};  // -127 * 3

        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.op_1      = '0;
        bus.op_2      = '0;
        bus.is_signed = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_in_ready",  64'(bus.in_ready),  64'd1);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_busy",      64'(bus.busy),      64'd0);
        check("rst_result",    64'(bus.result),    64'd0);
        rst = 1'b0;

        // Table-driven single operations.
        for (int i = 0; i < 10; i++) begin
            issue(vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].exp, 1'b0);
            check("busy_in_calc", 64'(bus.busy), 64'd1);
            wait_drain();
            check("idle_after_op", 64'(bus.in_ready), 64'd1);
        end

        // Backpressure: result held for 10 stalled cycles, new request ignored meanwhile.
        @(negedge clk);
        bus.out_ready = 1'b0;
        issue(8'h12, 8'h34, 1'b0, 16'h03A8, 1'b0);
        n = 0;
        while (!bus.out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("bp_valid_rise", 64'(bus.out_valid), 64'd1);
        bus.op_1     = 8'h11;
        bus.op_2     = 8'h22;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_out_valid", 64'(bus.out_valid), 64'd1);
            check("bp_result",    64'(bus.result),    64'h03A8);
            check("bp_in_ready",  64'(bus.in_ready),  64'd0);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        wait_drain();

        // Back-to-back: in_valid stays high, second accept lands the cycle after the result handshake.
        issue(8'd7, 8'd9, 1'b0, 16'd63, 1'b1);
        issue(8'hF9, 8'd9, 1'b1, 16'hFFC1, 1'b0);
        check("b2b_gap", 64'(acc_gap), 64'(ITER + 2));
        wait_drain();

        // Reset in the middle of CALC drops the operation.
        issue(8'h55, 8'h66, 1'b0, 16'h21DE, 1'b0);
        repeat (3) @(negedge clk);
        check("abort_busy", 64'(bus.busy), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        check("abort_in_ready",  64'(bus.in_ready),  64'd1);
        check("abort_out_valid", 64'(bus.out_valid), 64'd0);
        check("abort_result",    64'(bus.result),    64'd0);
        check("abort_busy_low",  64'(bus.busy),      64'd0);
        issue(8'd3, 8'd5, 1'b0, 16'd15, 1'b0);
        wait_drain();

        // Random operations against the reference model.
        for (int i = 0; i < 3000; i++) begin
            ra = WIDTH'($urandom);
            rb = WIDTH'($urandom);
            rs = 1'($urandom_range(0, 1));
            issue(ra, rb, rs, model(ra, rb, rs), 1'b0);
        end
        wait_drain();
        check("queue_empty", 64'(exp_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
